// File: rtl/pll_lock_monitor_pkg.sv
// Shared types and sizing helpers for the PLL lock supervisor.
package pll_lock_monitor_pkg;

    typedef enum logic [2:0] {
        RESET_PLL,
        WAIT_LOCK,
        STABILIZE,
        LOCKED,
        FAILED
    } state_e;

    // One counter is shared by all timed states, so size it for the longest window.
    function automatic int cnt_width(input int rst_cycles, input int timeout,
                                     input int stable_cycles);
        int m;
        m = rst_cycles;
        if (timeout > m) m = timeout;
        if (stable_cycles > m) m = stable_cycles;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchroniser for a single asynchronous level signal.
module bit_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_monitor.sv
// PLL supervisor: pulses PLL reset, waits for lock with timeout and retries,
// and qualifies done_o only after lock has been stable for a full window.
module pll_lock_monitor
    import pll_lock_monitor_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int TIMEOUT       = 4096,
    parameter int STABLE_CYCLES = 256,
    parameter int MAX_RETRIES   = 3,
    parameter int LOSS_W        = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              pllLock_i,
    input  logic              retry_i,
    output logic              pllRst_o,
    output logic              done_o,
    output logic              error_o,
    output logic [LOSS_W-1:0] lossCnt_o
);

    localparam int CW = cnt_width(RST_CYCLES, TIMEOUT, STABLE_CYCLES);
    localparam int RW = (MAX_RETRIES < 2) ? 1 : $clog2(MAX_RETRIES + 1);

    localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST     = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [RW-1:0] RET_MAX     = RW'(MAX_RETRIES);

    logic lock_s;

    bit_sync u_lock_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (pllLock_i),
        .q_o   (lock_s)
    );

    state_e            state_q,   state_d;
    logic [CW-1:0]     cnt_q,     cnt_d;
    logic [RW-1:0]     retries_q, retries_d;
    logic [LOSS_W-1:0] loss_q,    loss_d;
    logic              pll_rst_q, pll_rst_d;
    logic              done_q,    done_d;
    logic              error_q,   error_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        retries_d = retries_q;
        loss_d    = loss_q;
        unique case (state_q)
            RESET_PLL: begin
                if (cnt_q == RST_LAST) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_LOCK: begin
                // A lock seen on the last timeout cycle still wins.
                if (lock_s) begin
                    state_d = STABILIZE;
                    cnt_d   = '0;
                end else if (cnt_q == TO_LAST) begin
                    if (retries_q == RET_MAX) begin
                        state_d = FAILED;
                    end else begin
                        retries_d = retries_q + 1'b1;
                        state_d   = RESET_PLL;
                        cnt_d     = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STABILIZE: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d   = LOCKED;
                    retries_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LOCKED: begin
                if (!lock_s) begin
                    state_d = RESET_PLL;
                    cnt_d   = '0;
                    if (loss_q != '1) loss_d = loss_q + 1'b1;
                end
            end
            FAILED: begin
                if (retry_i) begin
                    state_d   = RESET_PLL;
                    cnt_d     = '0;
                    retries_d = '0;
                end
            end
            default: begin
                state_d = RESET_PLL;
                cnt_d   = '0;
            end
        endcase

        // Outputs follow the next state so they change on the same edge as it.
        pll_rst_d = (state_d == RESET_PLL) || (state_d == FAILED);
        done_d    = (state_d == LOCKED);
        error_d   = (state_d == FAILED);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= RESET_PLL;
            cnt_q     <= '0;
            retries_q <= '0;
            loss_q    <= '0;
            pll_rst_q <= 1'b1;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retries_q <= retries_d;
            loss_q    <= loss_d;
            pll_rst_q <= pll_rst_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    assign pllRst_o  = pll_rst_q;
    assign done_o    = done_q;
    assign error_o   = error_q;
    assign lossCnt_o = loss_q;

endmodule
